// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg
//   Shared definitions for the clock-divider run-time controller: default widths,
//   the reset divide value and the controller state encoding.
//   No ports (package).
package clk_div_ctrl_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BURST_W = 16;
  localparam int DEF_DIV_VAL = 1;

  // PEND is a RUN state that additionally owns a full shadow config register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  function automatic logic state_is_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if
//   Control/status bundle between the front-panel logic (master) and the
//   clock-divider controller (slave).
//   Signals:
//     start, stop          run control (stop wins over start)
//     cfg_valid/cfg_ready  config handshake, accepted when both high at posedge
//     cfg_div, cfg_burst   new terminal count and ticks-per-run (0 = free-run)
//     tick, clk_d          1-cycle enable pulse and registered divided clock
//     busy, done           running status and burst-complete pulse
interface clk_div_ctrl_if
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) ();

  logic               start;
  logic               stop;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               tick;
  logic               clk_d;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, cfg_valid, cfg_div, cfg_burst,
    input  cfg_ready, tick, clk_d, busy, done
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_div, cfg_burst,
    output cfg_ready, tick, clk_d, busy, done
  );

endinterface

// File: rtl/clk_div_ctrl_div_counter.sv
// clk_div_ctrl_div_counter
//   Prescale counter for the clock divider. Counts 0..div and wraps to 0 on the
//   terminal cycle, so one period is div+1 clocks.
//   Ports:
//     clk, rst   system clock, asynchronous active-high reset
//     clear      force count to 0 (has priority over enable)
//     enable     advance the count this cycle
//     div        terminal count
//     count      current count value
//     terminal   high while count == div
module clk_div_ctrl_div_counter
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == div);

  // Count is bounded by div because it restarts from 0 on the terminal cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (terminal) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Run-time controller for the clock-divider path. Owns the prescale counter,
//   sequences start/stop and finite bursts, and defers new divide settings to
//   the next period boundary so no short or long tick is ever produced.
//   Ports:
//     clk        system clock, all logic on posedge
//     rst        asynchronous, active-high reset
//     bus        clk_div_ctrl_if.slave: start/stop, config handshake
//                (cfg_valid/cfg_ready/cfg_div/cfg_burst) and status outputs
//                (tick, clk_d, busy, done)
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int          BURST_W = DEF_BURST_W,
  parameter int unsigned DEF_DIV = DEF_DIV_VAL
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_ctrl_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;

  logic [CNT_W-1:0]   div_r;
  logic [BURST_W-1:0] burst_r;
  logic [CNT_W-1:0]   shd_div;
  logic [BURST_W-1:0] shd_burst;
  logic [BURST_W-1:0] tick_cnt;

  logic               tick_r;
  logic               clk_d_r;
  logic               done_r;

  logic [CNT_W-1:0]   count;
  logic               terminal;

  logic               run_active;
  logic               cfg_ready;
  logic               cfg_accept;
  logic               go_start;
  logic               go_stop;
  logic               fire;
  logic               burst_last;
  logic               cnt_clear;

  logic               load_cfg;
  logic               load_shd;
  logic               cap_shd;

  // ------------------------------------------------------------------
  // Event decode
  // ------------------------------------------------------------------
  assign run_active = (state == ST_RUN) || (state == ST_PEND);
  assign cfg_ready  = (state != ST_PEND);
  assign cfg_accept = bus.cfg_valid && cfg_ready;
  assign go_start   = (state == ST_IDLE) && bus.start && !bus.stop;
  assign go_stop    = run_active && bus.stop;

  // A terminal edge only produces a tick when it is not pre-empted by stop.
  assign fire       = run_active && terminal && !bus.stop;

  // burst_r == 0 means free-run, so tick_cnt is only meaningful otherwise.
  assign burst_last = fire && (burst_r != '0) &&
                      (tick_cnt == (burst_r - BURST_W'(1)));

  // Counter sits at 0 whenever the controller is idle, which also gives the
  // zero start value on the edge that enters RUN.
  assign cnt_clear  = (state == ST_IDLE) || go_stop;

  clk_div_ctrl_div_counter #(
    .CNT_W (CNT_W)
  ) u_div_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (run_active),
    .div      (div_r),
    .count    (count),
    .terminal (terminal)
  );

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state. Stop has priority, then burst completion, then the
  // config handshake / shadow application.
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go_start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (go_stop || burst_last) begin
          state_nxt = ST_IDLE;
        end else if (cfg_accept) begin
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (go_stop || burst_last) begin
          state_nxt = ST_IDLE;
        end else if (fire) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output / strobe decode.
  // A config accepted on the same edge the run ends is written straight to
  // the live registers so it is not lost; a shadow waiting in PEND is
  // likewise applied when the run ends by stop or by burst completion.
  // ------------------------------------------------------------------
  always_comb begin
    load_cfg = 1'b0;
    load_shd = 1'b0;
    cap_shd  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_cfg = cfg_accept;
      end
      ST_RUN: begin
        if (cfg_accept) begin
          if (go_stop || burst_last) begin
            load_cfg = 1'b1;
          end else begin
            cap_shd = 1'b1;
          end
        end
      end
      ST_PEND: begin
        load_shd = go_stop || fire;
      end
      default: begin
        load_cfg = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Live and shadow configuration registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r     <= CNT_W'(DEF_DIV);
      burst_r   <= '0;
      shd_div   <= '0;
      shd_burst <= '0;
    end else begin
      if (load_cfg) begin
        div_r   <= bus.cfg_div;
        burst_r <= bus.cfg_burst;
      end else if (load_shd) begin
        div_r   <= shd_div;
        burst_r <= shd_burst;
      end
      if (cap_shd) begin
        shd_div   <= bus.cfg_div;
        shd_burst <= bus.cfg_burst;
      end
    end
  end

  // ------------------------------------------------------------------
  // Burst tick counter. Restarts on a shadow application because the new
  // burst length counts from the first period of the new setting.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (go_start) begin
      tick_cnt <= '0;
    end else if (fire) begin
      if (state == ST_PEND) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + BURST_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs. clk_d is forced low on start and stop but keeps its
  // level when a burst completes on its own.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
      clk_d_r <= 1'b0;
    end else begin
      tick_r <= fire;
      done_r <= burst_last;
      if (go_start || go_stop) begin
        clk_d_r <= 1'b0;
      end else if (fire) begin
        clk_d_r <= ~clk_d_r;
      end
    end
  end

  assign bus.tick      = tick_r;
  assign bus.clk_d     = clk_d_r;
  assign bus.done      = done_r;
  assign bus.busy      = state_is_busy(state);
  assign bus.cfg_ready = cfg_ready;

endmodule
